stopwatch_ctrl: RTL and testbench

Control FSM directly upstream of the stopwatch datapath. It conditions the user buttons, latches and clamps the switch preset, and produces a count-rate tick. It drives every datapath control input: init_ld_en, count_en, ctrSelect, InitVal, tcSelect and anReset. It consumes tcLimitReached to stop the run, and supports count-up-to-limit and count-down-to-zero modes at one count per tick.

---
 rtl/stopwatch_ctrl.sv | 142 ++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: conditions the buttons, latches and clamps the preset, and
// paces the datapath counter with a count-rate tick. All outputs are registered.
module stopwatch_ctrl #(
  parameter int unsigned TICK_DIV = 1_000_000,
  parameter int unsigned MAX_VAL  = 9999
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_btn,
  input  logic        stop_btn,
  input  logic        clear_btn,
  input  logic        mode,
  input  logic [13:0] sw_val,
  input  logic        tcLimitReached,
  output logic        init_ld_en,
  output logic        count_en,
  output logic [1:0]  ctrSelect,
  output logic [16:0] InitVal,
  output logic        tcSelect,
  output logic        anReset,
  output logic        running
);

  localparam int unsigned      TickW    = $clog2(TICK_DIV);
  localparam logic [TickW-1:0] TickLast = TickW'(TICK_DIV - 1);
  localparam logic [16:0]      MaxVal   = 17'(MAX_VAL);

  typedef enum logic [2:0] {
    StIdle, StLoad, StPreset, StReady, StRun, StPause, StDone
  } state_t;

  state_t           stateQ, stateD;
  logic [TickW-1:0] tickQ, tickD;
  logic             modeQ, modeD;
  logic             countEnD, initLdD, runD;
  logic [1:0]       ctrSelD;
  logic [16:0]      initValD, swExt, clampVal;

  // Button bits are {clear, stop, start}.
  logic [2:0] sync1Q, sync2Q, histQ, pulseQ;
  logic [1:0] armQ;
  logic       startP, stopP, clearP;

  assign startP = pulseQ[0];
  assign stopP  = pulseQ[1];
  assign clearP = pulseQ[2];

  // histQ starts high and only tracks the synchroniser once it holds real samples,
  // so a button already held at reset release never looks like a new press.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1Q <= '0;
      sync2Q <= '0;
      histQ  <= '1;
      pulseQ <= '0;
      armQ   <= '0;
    end else begin
      sync1Q <= {clear_btn, stop_btn, start_btn};
      sync2Q <= sync1Q;
      armQ   <= {armQ[0], 1'b1};
      if (armQ[1]) histQ <= sync2Q;
      pulseQ <= sync2Q & ~histQ;
    end
  end

  assign swExt    = {3'b000, sw_val};
  assign clampVal = (swExt > MaxVal) ? MaxVal : swExt;

  always_comb begin
    stateD   = stateQ;
    tickD    = tickQ;
    countEnD = 1'b0;
    case (stateQ)
      StIdle:   stateD = StLoad;
      StLoad:   stateD = StPreset;
      StPreset: stateD = StReady;
      StReady:  if (startP && !stopP) stateD = StRun;
      StRun: begin
        // Terminal count wins over the tick so the datapath never overshoots.
        if (tcLimitReached) begin
          stateD = StDone;
        end else if (stopP) begin
          stateD = StPause;
        end else if (tickQ == TickLast) begin
          tickD    = '0;
          countEnD = 1'b1;
        end else begin
          tickD = tickQ + 1'b1;
        end
      end
      StPause:  if (startP && !stopP) stateD = StRun;
      StDone:   stateD = StDone;
      default:  stateD = StIdle;
    endcase

    if (clearP && (stateQ != StIdle)) begin
      stateD   = StLoad;
      countEnD = 1'b0;
    end

    if (stateD == StLoad)   tickD    = '0;
    if (stateD == StPreset) countEnD = 1'b1;

    modeD    = (stateD == StLoad) ? mode : modeQ;
    initValD = (stateD == StLoad) ? clampVal : InitVal;
    initLdD  = (stateD == StLoad);
    runD     = (stateD == StRun);

    case (stateD)
      StIdle, StLoad: ctrSelD = 2'b11;
      StPreset:       ctrSelD = modeD ? 2'b00 : 2'b11;
      default:        ctrSelD = modeD ? 2'b10 : 2'b01;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateQ     <= StIdle;
      tickQ      <= '0;
      modeQ      <= 1'b0;
      init_ld_en <= 1'b0;
      count_en   <= 1'b0;
      ctrSelect  <= 2'b11;
      tcSelect   <= 1'b0;
      InitVal    <= '0;
      anReset    <= 1'b1;
      running    <= 1'b0;
    end else begin
      stateQ     <= stateD;
      tickQ      <= tickD;
      modeQ      <= modeD;
      init_ld_en <= initLdD;
      count_en   <= countEnD;
      ctrSelect  <= ctrSelD;
      tcSelect   <= modeD;
      InitVal    <= initValD;
      anReset    <= 1'b0;
      running    <= runD;
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: a behavioural datapath drives tcLimitReached; expectations
// come from count arithmetic (preset counts, TD spacing, fixed button latency).
module tb_stopwatch_ctrl;

  localparam int TD  = 4;
  localparam int MAX = 9999;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start_btn = 1'b0, stop_btn = 1'b0, clear_btn = 1'b0;
  logic        mode = 1'b0;
  logic [13:0] sw_val = '0;
  logic        tcLimitReached;
  logic        init_ld_en, count_en, tcSelect, anReset, running;
  logic [1:0]  ctrSelect;
  logic [16:0] InitVal;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  stopwatch_ctrl #(.TICK_DIV(TD), .MAX_VAL(MAX)) dut (
    .clk(clk), .reset(reset), .start_btn(start_btn), .stop_btn(stop_btn),
    .clear_btn(clear_btn), .mode(mode), .sw_val(sw_val), .tcLimitReached(tcLimitReached),
    .init_ld_en(init_ld_en), .count_en(count_en), .ctrSelect(ctrSelect), .InitVal(InitVal),
    .tcSelect(tcSelect), .anReset(anReset), .running(running)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Datapath model
  logic [16:0] dpInit = '0, dpTime = '0;
  always @(posedge clk) begin
    if (init_ld_en) dpInit <= InitVal;
    if (count_en) begin
      case (ctrSelect)
        2'b00:   dpTime <= dpInit;
        2'b01:   dpTime <= dpTime + 17'd1;
        2'b10:   dpTime <= dpTime - 17'd1;
        default: dpTime <= '0;
      endcase
    end
  end
  assign tcLimitReached = tcSelect ? (dpTime == 17'd0) : (dpTime == dpInit);

  // count_en pulse recorder: edge index and select of each pulse, plus width violations
  int         pulseCyc[$];
  logic [1:0] pulseSel[$];
  int         widthErr = 0;
  logic       prevEn = 1'b0;
  always @(negedge clk) begin
    if (count_en === 1'b1) begin
      pulseCyc.push_back(cyc);
      pulseSel.push_back(ctrSelect);
      if (prevEn) widthErr++;
    end
    prevEn = (count_en === 1'b1);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_btn(input logic [2:0] b);
    {clear_btn, stop_btn, start_btn} = b;
  endtask

  task automatic clear_log();
    pulseCyc.delete();
    pulseSel.delete();
    widthErr = 0;
  endtask

  // Press clear with a new preset; checks LOAD/PRESET/READY, then scrambles the inputs.
  task automatic load_preset(input logic m, input int v);
    int expV;
    expV = (v > MAX) ? MAX : v;
    mode = m; sw_val = 14'(v);
    set_btn(3'b100);
    step(4);
    set_btn(3'b000);
    checks++; if (init_ld_en !== 1'b1) begin errors++; $display("FAIL load_ld got=%b want=1", init_ld_en); end
    checks++; if (InitVal !== 17'(expV)) begin errors++; $display("FAIL load_initval got=%0d want=%0d", InitVal, expV); end
    step(1);
    checks++; if (count_en !== 1'b1 || ctrSelect !== (m ? 2'b00 : 2'b11) || tcSelect !== m) begin
      errors++; $display("FAIL preset_outs got en=%b sel=%b tc=%b want en=1 sel=%b tc=%b",
                         count_en, ctrSelect, tcSelect, (m ? 2'b00 : 2'b11), m);
    end
    step(1);
    checks++; if (count_en !== 1'b0 || init_ld_en !== 1'b0) begin
      errors++; $display("FAIL ready_outs got en=%b ld=%b want 0 0", count_en, init_ld_en);
    end
    mode = 1'($urandom); sw_val = 14'($urandom);
  endtask

  // From READY: start, run to DONE, check count count/spacing/select/final value.
  task automatic run_to_done(input logic m, input int v);
    int e, d, n, nAfter;
    logic [16:0] tAfter;
    clear_log();
    set_btn(3'b001);
    step(3);
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL start_early got=%b want=0", running); end
    step(1);
    set_btn(3'b000);
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL start_latency got=%b want=1", running); end
    e = cyc;
    n = 0;
    while (running !== 1'b0 && n < v * TD + 20) begin step(1); n++; end
    d = cyc;
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL done_timeout running=%b want=0", running); end
    checks++; if (pulseCyc.size() != v) begin errors++; $display("FAIL count_total got=%0d want=%0d", pulseCyc.size(), v); end
    if (pulseCyc.size() == v && v > 0) begin
      checks++; if (pulseCyc[0] - e != TD) begin errors++; $display("FAIL first_tick got=%0d want=%0d", pulseCyc[0] - e, TD); end
      for (int i = 1; i < v; i++) begin
        checks++; if (pulseCyc[i] - pulseCyc[i-1] != TD) begin
          errors++; $display("FAIL tick_spacing idx=%0d got=%0d want=%0d", i, pulseCyc[i] - pulseCyc[i-1], TD);
        end
      end
      for (int i = 0; i < v; i++) begin
        checks++; if (pulseSel[i] !== (m ? 2'b10 : 2'b01)) begin
          errors++; $display("FAIL count_sel idx=%0d got=%b want=%b", i, pulseSel[i], (m ? 2'b10 : 2'b01));
        end
      end
      checks++; if (d - pulseCyc[v-1] != 2) begin errors++; $display("FAIL done_delay got=%0d want=2", d - pulseCyc[v-1]); end
    end else if (v == 0) begin
      checks++; if (d - e != 1) begin errors++; $display("FAIL zero_done got=%0d want=1", d - e); end
    end
    checks++; if (widthErr != 0) begin errors++; $display("FAIL pulse_width got=%0d want=0", widthErr); end
    checks++; if (dpTime !== 17'(m ? 0 : v)) begin errors++; $display("FAIL final_time got=%0d want=%0d", dpTime, (m ? 0 : v)); end
    // DONE ignores start and stop
    nAfter = pulseCyc.size(); tAfter = dpTime;
    set_btn(3'b001); step(5); set_btn(3'b010); step(5); set_btn(3'b000); step(2);
    checks++; if (running !== 1'b0 || pulseCyc.size() != nAfter || dpTime !== tAfter) begin
      errors++; $display("FAIL done_hold got run=%b cnt=%0d time=%0d want run=0 cnt=%0d time=%0d",
                         running, pulseCyc.size(), dpTime, nAfter, tAfter);
    end
  endtask

  task automatic test_reset();
    mode = 1'b1; sw_val = 14'd3;
    reset = 1'b0;
    step(3);
    checks++; if (init_ld_en !== 1'b0 || count_en !== 1'b0 || ctrSelect !== 2'b11 || tcSelect !== 1'b0 ||
                  InitVal !== 17'd0 || anReset !== 1'b1 || running !== 1'b0) begin
      errors++; $display("FAIL reset_vals got ld=%b en=%b sel=%b tc=%b iv=%0d an=%b run=%b",
                         init_ld_en, count_en, ctrSelect, tcSelect, InitVal, anReset, running);
    end
    reset = 1'b1;
    step(1);
    checks++; if (init_ld_en !== 1'b1 || InitVal !== 17'd3 || anReset !== 1'b0) begin
      errors++; $display("FAIL edge1_load got ld=%b iv=%0d an=%b want 1 3 0", init_ld_en, InitVal, anReset);
    end
    step(1);
    checks++; if (init_ld_en !== 1'b0 || count_en !== 1'b1 || ctrSelect !== 2'b00 || tcSelect !== 1'b1) begin
      errors++; $display("FAIL edge2_preset got ld=%b en=%b sel=%b tc=%b want 0 1 00 1",
                         init_ld_en, count_en, ctrSelect, tcSelect);
    end
    step(1);
    checks++; if (count_en !== 1'b0 || running !== 1'b0 || dpTime !== 17'd3) begin
      errors++; $display("FAIL edge3_ready got en=%b run=%b time=%0d want 0 0 3", count_en, running, dpTime);
    end
  endtask

  task automatic test_mode1_run();
    run_to_done(1'b1, 3);
  endtask

  task automatic test_clear_in_done();
    load_preset(1'b0, 7);
    run_to_done(1'b0, 7);
  endtask

  task automatic test_clamp();
    int n;
    load_preset(1'b0, 10000);
    load_preset(1'b0, 9999);
    load_preset(1'b0, 16383);
    checks++; if (tcSelect !== 1'b0) begin errors++; $display("FAIL clamp_tcsel got=%b want=0", tcSelect); end
    clear_log();
    set_btn(3'b001); step(4); set_btn(3'b000);
    n = 0;
    while (pulseCyc.size() < 3 && n < 5 * TD) begin step(1); n++; end
    step(1);
    checks++; if (dpTime !== 17'd3) begin errors++; $display("FAIL clamp_upcount got=%0d want=3", dpTime); end
    for (int i = 0; i < pulseSel.size(); i++) begin
      checks++; if (pulseSel[i] !== 2'b01) begin errors++; $display("FAIL clamp_sel idx=%0d got=%b want=01", i, pulseSel[i]); end
    end
  endtask

  task automatic test_pause();
    int e, s, r, adv, nBefore, n, rem;
    load_preset(1'b0, 6);
    clear_log();
    set_btn(3'b001); step(4); set_btn(3'b000);
    e = cyc;
    n = 0;
    while (pulseCyc.size() < 1 && n < 3 * TD) begin step(1); n++; end
    step($urandom_range(0, 3));
    set_btn(3'b010);
    step(3);
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL stop_early got=%b want=1", running); end
    step(1);
    set_btn(3'b000);
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL stop_latency got=%b want=0", running); end
    s = cyc;
    adv = s - 1 - e;
    nBefore = pulseCyc.size();
    checks++; if (nBefore != adv / TD) begin errors++; $display("FAIL pause_counts got=%0d want=%0d", nBefore, adv / TD); end
    step($urandom_range(3, 10));
    checks++; if (pulseCyc.size() != nBefore) begin errors++; $display("FAIL pause_quiet got=%0d want=%0d", pulseCyc.size(), nBefore); end
    set_btn(3'b001); step(4); set_btn(3'b000);
    r = cyc;
    rem = TD - (adv % TD);
    n = 0;
    while (pulseCyc.size() <= nBefore && n < 3 * TD) begin step(1); n++; end
    checks++; if (pulseCyc.size() <= nBefore) begin
      errors++; $display("FAIL resume_timeout got=%0d want>%0d", pulseCyc.size(), nBefore);
    end else if (pulseCyc[nBefore] - r != rem) begin
      errors++; $display("FAIL resume_fraction got=%0d want=%0d", pulseCyc[nBefore] - r, rem);
    end
    n = 0;
    while (running !== 1'b0 && n < 8 * TD) begin step(1); n++; end
    checks++; if (pulseCyc.size() != 6 || dpTime !== 17'd6 || running !== 1'b0) begin
      errors++; $display("FAIL pause_final got cnt=%0d time=%0d run=%b want 6 6 0", pulseCyc.size(), dpTime, running);
    end
  endtask

  task automatic test_back_to_back();
    int n, nHold;
    load_preset(1'b1, 5);
    set_btn(3'b011); step(6); set_btn(3'b000); step(2);
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL ready_startstop got=%b want=0", running); end
    clear_log();
    set_btn(3'b001); step(4); set_btn(3'b000);
    n = 0;
    while (pulseCyc.size() < 1 && n < 3 * TD) begin step(1); n++; end
    set_btn(3'b011); step(4); set_btn(3'b000);
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL run_startstop got=%b want=0", running); end
    nHold = pulseCyc.size();
    step(3 * TD);
    checks++; if (pulseCyc.size() != nHold || running !== 1'b0) begin
      errors++; $display("FAIL run_startstop_hold got cnt=%0d run=%b want %0d 0", pulseCyc.size(), running, nHold);
    end
  endtask

  task automatic test_random();
    logic m;
    int v;
    for (int i = 0; i < 6; i++) begin
      m = (i < 2) ? 1'(i) : 1'($urandom_range(0, 1));
      v = (i < 2) ? 0 : int'($urandom_range(1, 12));
      load_preset(m, v);
      run_to_done(m, v);
    end
  endtask

  task automatic test_reset_mid_run();
    int n;
    load_preset(1'b1, 9);
    set_btn(3'b001); step(4); set_btn(3'b000);
    n = 0;
    while (count_en !== 1'b1 && n < 3 * TD) begin step(1); n++; end
    checks++; if (count_en !== 1'b1) begin errors++; $display("FAIL midrun_tick_timeout got=%b want=1", count_en); end
    reset = 1'b0;
    set_btn(3'b001);
    #1;
    checks++; if (count_en !== 1'b0 || anReset !== 1'b1 || ctrSelect !== 2'b11 || running !== 1'b0 ||
                  init_ld_en !== 1'b0 || InitVal !== 17'd0 || tcSelect !== 1'b0) begin
      errors++; $display("FAIL async_reset got en=%b an=%b sel=%b run=%b ld=%b iv=%0d tc=%b",
                         count_en, anReset, ctrSelect, running, init_ld_en, InitVal, tcSelect);
    end
    step(2);
    mode = 1'b0; sw_val = 14'd2;
    reset = 1'b1;
    step(12);
    checks++; if (running !== 1'b0 || count_en !== 1'b0) begin
      errors++; $display("FAIL held_through_reset got run=%b en=%b want 0 0", running, count_en);
    end
    set_btn(3'b000); step(3);
    run_to_done(1'b0, 2);
  endtask

  initial begin
    test_reset();
    test_mode1_run();
    test_clear_in_done();
    test_clamp();
    test_pause();
    test_back_to_back();
    test_random();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
